// File: rtl/euler_pkg.sv
// Shared constants, arithmetic width and the fixed register map of the Euler solver datapath.
// Also provides the 4-bit lookahead carry helper used by the CLA adder.
package euler_pkg;

  localparam int DEF_ADDRESS_WIDTH = 13;
  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_DEPTH         = 100;
  localparam int ARITH_W           = 16;

  // Word addresses the Euler controller uses for its operands and results
  typedef enum logic [DEF_ADDRESS_WIDTH-1:0] {
    REG_A    = 13'd1,
    REG_B    = 13'd2,
    REG_N    = 13'd3,
    REG_M    = 13'd4,
    REG_H    = 13'd5,
    REG_X    = 13'd6,
    REG_XNEW = 13'd7,
    REG_U    = 13'd8,
    REG_RES1 = 13'd11,
    REG_RES2 = 13'd12
  } reg_map_e;

  // Carries into bits 0..3 of a 4-bit group, each a flat sum of products
  function automatic logic [3:0] cla4_carries(input logic [3:0] p, input logic [3:0] g,
                                              input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

endpackage

// File: rtl/cla_add_sub16.sv
// 16-bit carry-lookahead add/subtract: four 4-bit groups with group P/G feeding
// a second-level lookahead unit, so no carry ripples between groups.
module cla_add_sub16 import euler_pkg::*; (
  input  logic               mode,
  input  logic [ARITH_W-1:0] a,
  input  logic [ARITH_W-1:0] b,
  input  logic               cin,
  output logic [ARITH_W-1:0] sum,
  output logic               cout
);

  logic [ARITH_W-1:0] bb;
  logic [ARITH_W-1:0] p;
  logic [ARITH_W-1:0] g;
  logic [ARITH_W-1:0] c;
  logic [3:0]         grp_p;
  logic [3:0]         grp_g;
  logic [4:0]         grp_c;

  always_comb begin
    bb = b ^ {ARITH_W{mode}};
    p  = a ^ bb;
    g  = a & bb;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // Subtract is A + ~B with the borrow-in inverted into a carry-in
    grp_c[0] = cin ^ mode;
    grp_c[1] = grp_g[0] | (grp_p[0] & grp_c[0]);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & grp_c[0]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = cla4_carries(p[4*k +: 4], g[4*k +: 4], grp_c[k]);
    end
    sum  = p ^ c;
    cout = grp_c[4];
  end

endmodule

// File: rtl/euler_mem_arith.sv
// Euler solver storage and arithmetic core: 2R/1W word RAM with async clear,
// a CLA add/subtract port and an unsigned 16x16 shift-add array multiplier.
module euler_mem_arith import euler_pkg::*; #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [ADDRESS_WIDTH-1:0] RD_ADDR1,
  input  logic [ADDRESS_WIDTH-1:0] RD_ADDR2,
  input  logic [ADDRESS_WIDTH-1:0] WR_ADDR,
  output logic [DATA_WIDTH-1:0]    RD_DATA1,
  output logic [DATA_WIDTH-1:0]    RD_DATA2,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  input  logic                     ADD_MODE,
  input  logic [ARITH_W-1:0]       ADD_A,
  input  logic [ARITH_W-1:0]       ADD_B,
  input  logic                     ADD_CIN,
  output logic [ARITH_W-1:0]       ADD_SUM,
  output logic                     ADD_COUT,
  output logic                     ADD_INVALID,
  input  logic [ARITH_W-1:0]       MUL_A,
  input  logic [ARITH_W-1:0]       MUL_B,
  input  logic                     MUL_EN,
  output logic [ARITH_W-1:0]       MUL_P,
  output logic                     MUL_OVF
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Out-of-range writes are dropped rather than aliased onto the low index bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (WR_EN && (WR_ADDR < DEPTH_A)) begin
      mem[WR_ADDR[IDX_W-1:0]] <= WR_DATA;
    end
  end

  assign RD_DATA1 = (RD_ADDR1 < DEPTH_A) ? mem[RD_ADDR1[IDX_W-1:0]] : '0;
  assign RD_DATA2 = (RD_ADDR2 < DEPTH_A) ? mem[RD_ADDR2[IDX_W-1:0]] : '0;

  cla_add_sub16 u_add (
    .mode (ADD_MODE),
    .a    (ADD_A),
    .b    (ADD_B),
    .cin  (ADD_CIN),
    .sum  (ADD_SUM),
    .cout (ADD_COUT)
  );

  // Overflow: effective operand signs agree but the result sign does not
  assign ADD_INVALID = (ADD_A[ARITH_W-1] == (ADD_B[ARITH_W-1] ^ ADD_MODE)) &&
                       (ADD_SUM[ARITH_W-1] != ADD_A[ARITH_W-1]);

  // Row i adds the i-th partial product to the running upper half, retires
  // one low product bit and shifts the carry back into the upper half.
  logic [ARITH_W-1:0] acc      [0:ARITH_W];
  logic [ARITH_W-1:0] row_sum  [0:ARITH_W-1];
  logic               row_cout [0:ARITH_W-1];
  logic [ARITH_W-1:0] prod_lo;

  assign acc[0] = '0;

  for (genvar i = 0; i < ARITH_W; i++) begin : g_row
    logic [ARITH_W-1:0] pp;
    assign pp = MUL_B[i] ? MUL_A : '0;

    cla_add_sub16 u_row (
      .mode (1'b0),
      .a    (acc[i]),
      .b    (pp),
      .cin  (1'b0),
      .sum  (row_sum[i]),
      .cout (row_cout[i])
    );

    assign prod_lo[i] = row_sum[i][0];
    assign acc[i+1]   = {row_cout[i], row_sum[i][ARITH_W-1:1]};
  end

  assign MUL_P   = MUL_EN ? prod_lo : '0;
  assign MUL_OVF = MUL_EN & (|acc[ARITH_W]);

endmodule

// File: tb/tb_euler_mem_arith.sv
// Directed bench for euler_mem_arith: RAM reset/write/read boundaries, adder and
// multiplier corner vectors, then a short random sweep against behavioural arithmetic.
module tb_euler_mem_arith;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_EN;
  logic [12:0] RD_ADDR1, RD_ADDR2, WR_ADDR;
  logic [63:0] RD_DATA1, RD_DATA2, WR_DATA;
  logic        ADD_MODE, ADD_CIN;
  logic [15:0] ADD_A, ADD_B, ADD_SUM;
  logic        ADD_COUT, ADD_INVALID;
  logic [15:0] MUL_A, MUL_B, MUL_P;
  logic        MUL_EN, MUL_OVF;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  euler_mem_arith dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN),
    .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .WR_ADDR(WR_ADDR),
    .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2), .WR_DATA(WR_DATA),
    .ADD_MODE(ADD_MODE), .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN),
    .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT), .ADD_INVALID(ADD_INVALID),
    .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_EN(MUL_EN),
    .MUL_P(MUL_P), .MUL_OVF(MUL_OVF)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [12:0] addr, input logic [63:0] data);
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = addr; WR_DATA = data;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [12:0] a1, input logic [12:0] a2,
                        input logic [63:0] e1, input logic [63:0] e2);
    RD_ADDR1 = a1; RD_ADDR2 = a2;
    #1;
    chk({tag, "_p1"}, RD_DATA1, e1);
    chk({tag, "_p2"}, RD_DATA2, e2);
  endtask

  task automatic add_chk(input string tag, input logic mode, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] e_sum,
                         input logic e_cout, input logic e_inv);
    ADD_MODE = mode; ADD_A = a; ADD_B = b; ADD_CIN = cin;
    #1;
    chk({tag, "_sum"}, {48'd0, ADD_SUM}, {48'd0, e_sum});
    chk({tag, "_cout"}, {63'd0, ADD_COUT}, {63'd0, e_cout});
    chk({tag, "_inv"}, {63'd0, ADD_INVALID}, {63'd0, e_inv});
  endtask

  task automatic mul_chk(input string tag, input logic en, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] e_p, input logic e_ovf);
    MUL_EN = en; MUL_A = a; MUL_B = b;
    #1;
    chk({tag, "_p"}, {48'd0, MUL_P}, {48'd0, e_p});
    chk({tag, "_ovf"}, {63'd0, MUL_OVF}, {63'd0, e_ovf});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rmode, rcin, e_cout, e_inv;
    logic [16:0] r17;
    logic [31:0] p32;
    int          sres;

    RST = 1'b1; WR_EN = 1'b0; RD_ADDR1 = '0; RD_ADDR2 = '0; WR_ADDR = '0; WR_DATA = '0;
    ADD_MODE = 1'b0; ADD_A = '0; ADD_B = '0; ADD_CIN = 1'b0;
    MUL_A = '0; MUL_B = '0; MUL_EN = 1'b0;

    repeat (2) @(negedge CLK);
    rd_chk("reset_read", 13'd6, 13'd0, 64'd0, 64'd0);
    RST = 1'b0;

    // Writes, dual-port reads and address boundaries
    wr(13'd6, 64'h1234);
    rd_chk("same_addr", 13'd6, 13'd6, 64'h1234, 64'h1234);
    wr(13'd0, 64'hAAAA_5555_0000_FFFF);
    wr(13'd99, 64'hDEAD_BEEF_CAFE_F00D);
    rd_chk("addr0_addr99", 13'd0, 13'd99, 64'hAAAA_5555_0000_FFFF, 64'hDEAD_BEEF_CAFE_F00D);
    rd_chk("out_of_range", 13'd150, 13'd100, 64'd0, 64'd0);
    wr(13'd134, 64'h1111);
    wr(13'd4102, 64'h2222);
    wr(13'd100, 64'h3333);
    rd_chk("no_alias", 13'd6, 13'd100, 64'h1234, 64'd0);

    // Read during write: old word before the edge, new word after it
    @(negedge CLK);
    WR_EN = 1'b1; WR_ADDR = 13'd6; WR_DATA = 64'hBEEF;
    rd_chk("rdw_before", 13'd6, 13'd0, 64'h1234, 64'hAAAA_5555_0000_FFFF);
    @(posedge CLK);
    #1;
    chk("rdw_after", RD_DATA1, 64'hBEEF);
    @(negedge CLK);
    WR_EN = 1'b0;

    // Mid-cycle reset clears at once and blocks writes while high
    #2 RST = 1'b1;
    rd_chk("async_clear", 13'd6, 13'd99, 64'd0, 64'd0);
    WR_EN = 1'b1; WR_ADDR = 13'd6; WR_DATA = 64'hFFFF;
    @(posedge CLK);
    @(negedge CLK);
    WR_EN = 1'b0; RST = 1'b0;
    rd_chk("wr_blocked", 13'd6, 13'd0, 64'd0, 64'd0);

    // Adder corners
    add_chk("add_7fff_inc", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    add_chk("add_ffff_cin", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    add_chk("sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    add_chk("sub_7_5", 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    add_chk("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    add_chk("sub_borrow", 1'b1, 16'h000A, 16'h0003, 1'b1, 16'h0006, 1'b1, 1'b0);
    add_chk("add_plain", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    add_chk("add_grp_carry", 1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Multiplier corners
    mul_chk("mul_300x200", 1'b1, 16'd300, 16'd200, 16'hEA60, 1'b0);
    mul_chk("mul_300x300", 1'b1, 16'd300, 16'd300, 16'h5F90, 1'b1);
    mul_chk("mul_disabled", 1'b0, 16'd300, 16'd300, 16'h0000, 1'b0);
    mul_chk("mul_ffff_sq", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    mul_chk("mul_zero", 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    mul_chk("mul_256x256", 1'b1, 16'd256, 16'd256, 16'h0000, 1'b1);
    mul_chk("mul_255x257", 1'b1, 16'd255, 16'd257, 16'hFFFF, 1'b0);

    // Random sweep against behavioural add, subtract and multiply
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rmode = 1'($urandom_range(0, 1));
      rcin  = 1'($urandom_range(0, 1));
      if (rmode) begin
        r17    = {1'b0, ra} - {1'b0, rb} - {16'd0, rcin};
        e_cout = ~r17[16];
        sres   = int'($signed(ra)) - int'($signed(rb)) - int'(rcin);
      end else begin
        r17    = {1'b0, ra} + {1'b0, rb} + {16'd0, rcin};
        e_cout = r17[16];
        sres   = int'($signed(ra)) + int'($signed(rb)) + int'(rcin);
      end
      e_inv = (sres > 32767) || (sres < -32768);
      add_chk("rand_add", rmode, ra, rb, rcin, r17[15:0], e_cout, e_inv);
      p32 = {16'd0, ra} * {16'd0, rb};
      mul_chk("rand_mul", 1'b1, ra, rb, p32[15:0], |p32[31:16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
